mmio_uart_tx: RTL
=================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter on the CPU data bus (mem_addr/mem_wr_sig/mem_wr_data/mem_rd_data),
//  a peer of the data RAM. It consumes CPU stores to a small register window, buffers bytes in a FIFO
//  and serialises them 8N1 on a single tx line. It gives programs observable output beyond RAM.
// PARAMETERS
//  BASE_ADDR    32'h0000_1000  byte address of register window (3 words, word-aligned)
//  FIFO_DEPTH   4              TX byte FIFO entries (power of two, >=2)
//  DEFAULT_DIV  16             reset value of baud divisor (clk cycles per bit)
// PORTS
//  clk      in   1   rising-edge clock
//  reset    in   1   asynchronous, active-high reset
//  wr_sig   in   1   CPU store strobe, sampled at rising clk edge
//  addr     in   32  CPU byte address
//  wr_data  in   32  CPU store data
//  rd_data  out  32  read data for addr (combinational); 0 when addr outside window
//  hit      out  1   addr within window (combinational); bus mux selects rd_data on hit
//  tx       out  1   serial line, idle high, registered
// BEHAVIOUR
//  Register map (offsets from BASE_ADDR; other offsets are not hits):
//   +0 TXDATA  W: push wr_data[7:0] into FIFO; R: 0
//   +4 STATUS  R: {28'b0, ovf, empty, full, busy}; W: wr_data[3]=1 clears ovf, other bits ignored
//   +8 DIV     R/W: 16-bit divisor in [15:0], upper bits read 0; write of 0 stores 1
//  Reset values: tx=1, FIFO empty, busy=0, ovf=0, DIV=DEFAULT_DIV, FSM=IDLE; rd_data/hit follow addr.
//  Store to TXDATA while full: byte dropped, ovf set (sticky). If FSM pops in the same cycle the
//   store is accepted (pop frees slot first), ovf unchanged.
//  FSM states: IDLE, START, DATA, STOP.
//   IDLE:  FIFO non-empty -> pop byte into shift reg, latch DIV into bit_div, tx<=0, ->START.
//   START: after bit_div cycles -> tx<=bit0, bit_idx<=0, ->DATA.
//   DATA:  every bit_div cycles shift LSB-first; after bit 7's period -> tx<=1, ->STOP.
//   STOP:  after bit_div cycles -> if FIFO non-empty pop next byte and go directly to START
//          (tx<=0, back-to-back, no idle bit), else ->IDLE.
//  Bit counter: 16-bit down-counter reloaded with bit_div-1 on each bit edge; frame = 10*bit_div cycles.
//  DIV writes mid-frame take effect at the next frame only (bit_div latched at pop).
//  busy = (FSM != IDLE); empty/full from FIFO counts, not pointer compare.
//  Latency: TXDATA store at edge N with FSM IDLE and FIFO empty -> tx low from edge N+1.
//  Reset mid-frame: tx forced high asynchronously, FIFO contents lost, no partial frame resumes.
//  Store to DIV and read of STATUS in the same cycle: STATUS reflects pre-edge state.
// STRUCTURE
//  Shared parameters.vh: register offsets (UART_TXDATA_OFF=0, UART_STATUS_OFF=4, UART_DIV_OFF=8),
//   STATUS bit indices, FSM state encodings (2-bit localparams).
//  Sub-module sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH): push/pop/full/empty, count-based,
//   simultaneous push+pop when full or empty handled internally; reusable by a later RX block.
//  Top: address decode, register file (DIV, ovf), FSM + bit counter + shift register.
// TESTING
//  1 DIV=4, store 0x55 to +0 -> tx: 0 for 4 clk, then 1,0,1,0,1,0,1,0 (4 clk each), 1; busy 40 clk.
//  2 Five stores 0x41..0x45 back-to-back with DIV=16 while idle -> first pops immediately, four
//    buffered, no ovf; tx carries 5 contiguous frames, 800 clk total, stop bit directly to start.
//  3 DIV=16, FIFO filled while transmitting, one more store -> byte dropped, STATUS=0x9 (ovf,busy,
//    not full after next pop); write 0x8 to +4 -> ovf clears.
//  4 Write DIV=2 mid-frame at DIV=8 -> current frame stays 80 clk, next frame 20 clk; write DIV=0 -> reads 1.
//  5 Assert reset during DATA bit 3 -> tx=1 same cycle, STATUS reads 0x4, DIV reads 16.
//  6 Reads at BASE_ADDR+12 and BASE_ADDR-4 -> hit=0, rd_data=0; stores there change nothing.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg: register offsets, STATUS bit positions and FSM encoding
// shared by the memory-mapped UART transmitter.
package mmio_uart_tx_pkg;

    localparam logic [31:0] UART_TXDATA_OFF = 32'd0;
    localparam logic [31:0] UART_STATUS_OFF = 32'd4;
    localparam logic [31:0] UART_DIV_OFF    = 32'd8;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: count-based synchronous FIFO; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle, and a pop of an empty FIFO is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = count_q == '0;
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q <= do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            count_q  <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO,
// programmable baud divisor and sticky overflow flag.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_sig,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        hit,
    output logic        tx
);

    state_e      state_q, state_d;
    logic [15:0] div_q, div_d, bit_div_q, bit_div_d, cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d, fifo_dout;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        tx_q, tx_d, ovf_q, ovf_d;
    logic        sel_data, sel_stat, sel_div, push, pop, busy, bit_done;
    logic        fifo_full, fifo_empty;
    logic [31:0] off;
    logic        unused_bits;

    assign off         = addr - BASE_ADDR;
    assign sel_data    = off == UART_TXDATA_OFF;
    assign sel_stat    = off == UART_STATUS_OFF;
    assign sel_div     = off == UART_DIV_OFF;
    assign hit         = sel_data || sel_stat || sel_div;
    assign busy        = state_q != S_IDLE;
    assign bit_done    = cnt_q == 16'd0;
    assign push        = wr_sig && sel_data;
    assign pop         = !fifo_empty && (state_q == S_IDLE || (state_q == S_STOP && bit_done));
    assign tx          = tx_q;
    assign unused_bits = ^wr_data[31:16];

    assign rd_data = sel_stat ? {28'b0, ovf_q, fifo_empty, fifo_full, busy} :
                     sel_div  ? {16'b0, div_q} : 32'b0;

    // A pop in the same cycle frees a slot, so only an unpopped full FIFO drops the byte.
    assign ovf_d = (push && fifo_full && !pop) ? 1'b1 :
                   (wr_sig && sel_stat && wr_data[ST_OVF]) ? 1'b0 : ovf_q;
    assign div_d = (wr_sig && sel_div) ? ((wr_data[15:0] == 16'd0) ? 16'd1 : wr_data[15:0]) : div_q;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .din_i   (wr_data[7:0]),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = fifo_empty ? S_IDLE : S_START;
            S_START: state_d = bit_done ? S_DATA : S_START;
            S_DATA:  state_d = (bit_done && bit_idx_q == 3'd7) ? S_STOP : S_DATA;
            S_STOP:  state_d = !bit_done ? S_STOP : fifo_empty ? S_IDLE : S_START;
        endcase
    end

    // bit_div is captured at pop so divisor writes only affect the next frame.
    always_comb begin
        bit_div_d = pop ? div_q : bit_div_q;
        cnt_d     = pop ? div_q - 16'd1 : (state_q == S_IDLE) ? cnt_q :
                    bit_done ? bit_div_q - 16'd1 : cnt_q - 16'd1;
        shift_d   = pop ? fifo_dout : (state_q == S_DATA && bit_done) ? shift_q >> 1 : shift_q;
        bit_idx_d = (state_q == S_START) ? 3'd0 :
                    (state_q == S_DATA && bit_done) ? bit_idx_q + 3'd1 : bit_idx_q;
        tx_d      = pop ? 1'b0 : !bit_done ? tx_q :
                    (state_q == S_START) ? shift_q[0] :
                    (state_q == S_DATA) ? ((bit_idx_q == 3'd7) ? 1'b1 : shift_q[1]) : 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q     <= DEFAULT_DIV;
            bit_div_q <= DEFAULT_DIV;
            cnt_q     <= 16'd0;
            shift_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            bit_div_q <= bit_div_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule
